rssb_sequencer: RTL and testbench

- Single-clock driver/observer for the 1-bit RSSB execution core.
- Holds a small operand program. Sequences the core's two-phase step as one-cycle phase strobes and presents the operand pair each step.
- Tracks the core's skip-on-borrow flag to advance its program counter, and streams a per-step trace {pc, flag, result} out through a ready/valid FIFO.

---
 rtl/rssb_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rssb_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_sequencer.sv
// Driver/observer for the 1-bit RSSB core: holds an operand program, walks the
// core through its two-phase step and streams a {pc, flag, result} trace.
module rssb_sequencer #(
  parameter int unsigned BW     = 1,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned TDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  input  logic [AW-1:0]      ld_addr,
  input  logic [BW-1:0]      ld_data,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        n_steps,
  output logic               busy,
  output logic               done,
  output logic               cpu_rst_n,
  output logic               cpu_ena,
  output logic               cpu_ph1,
  output logic               cpu_ph2,
  output logic [BW-1:0]      cpu_data0,
  output logic [BW-1:0]      cpu_data1,
  input  logic               cpu_flag,
  input  logic [BW-1:0]      cpu_result,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [AW+BW:0]     trace_data
);

  localparam int unsigned TW  = AW + 1 + BW;
  localparam int unsigned TAW = $clog2(TDEPTH);

  typedef enum logic [2:0] {
    StIdle, StClear, StSetup, StPh1, StPh2, StSample, StDone
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   pc_q;
  logic            flag_q;
  logic [15:0]     cnt_q;
  logic [15:0]     nsteps_q;

  logic [BW-1:0]   mem_q  [DEPTH];
  logic [TW-1:0]   fifo_q [TDEPTH];
  logic [TAW:0]    wptr_q;
  logic [TAW:0]    rptr_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [AW-1:0]   pc_step;
  logic [AW-1:0]   pc_step_p1;
  logic [AW-1:0]   pc_p1;
  logic [15:0]     cnt_inc;
  logic            last_step;

  // FIFO status, handshakes and next-pc arithmetic
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[TAW] != rptr_q[TAW]) &&
                 (wptr_q[TAW-1:0] == rptr_q[TAW-1:0]);
    pop        = !fifo_empty && trace_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    push       = (state_q == StSample) && !abort && (!fifo_full || pop);
    // A set flag means the core consumed mem[pc+1], so that word is skipped.
    pc_step    = pc_q + AW'(1) + AW'(flag_q);
    pc_step_p1 = pc_step + AW'(1);
    pc_p1      = pc_q + AW'(1);
    cnt_inc    = cnt_q + 16'd1;
    last_step  = (cnt_inc == nsteps_q);
    trace_valid = !fifo_empty;
    trace_data  = fifo_q[rptr_q[TAW-1:0]];
  end

  // Program memory: writable only while idle, never reset
  always_ff @(posedge clk) begin
    if (!busy && ld_valid) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Trace FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q[TAW-1:0]] <= {pc_q, cpu_flag, cpu_result};
    end
  end

  // Trace FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Sequencer FSM; all core-facing outputs are registered on entry to a state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      nsteps_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rst_n <= 1'b1;
      cpu_ena   <= 1'b0;
      cpu_ph1   <= 1'b0;
      cpu_ph2   <= 1'b0;
      cpu_data0 <= '0;
      cpu_data1 <= '0;
    end else begin
      cpu_ph1   <= 1'b0;
      cpu_ph2   <= 1'b0;
      cpu_rst_n <= 1'b1;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        done    <= 1'b0;
        cpu_ena <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (start && !abort) begin
              state_q   <= StClear;
              nsteps_q  <= n_steps;
              pc_q      <= '0;
              flag_q    <= 1'b0;
              cnt_q     <= '0;
              busy      <= 1'b1;
              done      <= 1'b0;
              cpu_rst_n <= 1'b0;
            end
          end
          StClear: begin
            if (nsteps_q == 16'd0) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q   <= StSetup;
              cpu_ena   <= 1'b1;
              cpu_data0 <= mem_q[pc_q];
              cpu_data1 <= mem_q[pc_p1];
            end
          end
          StSetup: begin
            state_q <= StPh1;
            cpu_ph1 <= 1'b1;
          end
          StPh1: begin
            state_q <= StPh2;
            cpu_ph2 <= 1'b1;
          end
          StPh2: begin
            state_q <= StSample;
          end
          StSample: begin
            // Without a push we simply hold here with the core enabled.
            if (push) begin
              pc_q   <= pc_step;
              flag_q <= cpu_flag;
              cnt_q  <= cnt_inc;
              if (last_step) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_ena <= 1'b0;
              end else begin
                state_q   <= StSetup;
                cpu_data0 <= mem_q[pc_step];
                cpu_data1 <= mem_q[pc_step_p1];
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rssb_sequencer.sv
// Self-checking bench for rssb_sequencer with a behavioural 1-bit RSSB core.
module tb_rssb_sequencer;

  localparam int unsigned BW     = 1;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 2;
  localparam int unsigned TDEPTH = 4;
  localparam int unsigned TW     = AW + 1 + BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [BW-1:0] ld_data;
  logic          start;
  logic          abort;
  logic [15:0]   n_steps;
  logic          busy;
  logic          done;
  logic          cpu_rst_n;
  logic          cpu_ena;
  logic          cpu_ph1;
  logic          cpu_ph2;
  logic [BW-1:0] cpu_data0;
  logic [BW-1:0] cpu_data1;
  logic          cpu_flag;
  logic [BW-1:0] cpu_result;
  logic          trace_valid;
  logic          trace_ready;
  logic [TW-1:0] trace_data;

  rssb_sequencer #(
    .BW     (BW),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TDEPTH (TDEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .start       (start),
    .abort       (abort),
    .n_steps     (n_steps),
    .busy        (busy),
    .done        (done),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_ena     (cpu_ena),
    .cpu_ph1     (cpu_ph1),
    .cpu_ph2     (cpu_ph2),
    .cpu_data0   (cpu_data0),
    .cpu_data1   (cpu_data1),
    .cpu_flag    (cpu_flag),
    .cpu_result  (cpu_result),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural core: ph1 latches the flag-selected operand, ph2 computes
  // operand - acc, keeping the difference and raising flag on borrow.
  logic c_flag = 1'b0;
  logic c_acc  = 1'b0;
  logic c_op   = 1'b0;
  always @(posedge clk) begin
    if (!cpu_rst_n) begin
      c_flag <= 1'b0;
      c_acc  <= 1'b0;
      c_op   <= 1'b0;
    end else if (cpu_ena && cpu_ph1) begin
      c_op <= c_flag ? cpu_data1 : cpu_data0;
    end else if (cpu_ena && cpu_ph2) begin
      {c_flag, c_acc} <= {1'b0, c_op} - {1'b0, c_acc};
    end
  end
  assign cpu_flag   = c_flag;
  assign cpu_result = c_acc;

  // Scoreboards
  logic [TW-1:0]   trace_q [$];
  logic [2*BW-1:0] ops_q   [$];
  logic [BW-1:0]   tb_mem  [DEPTH];

  // Reference run: operand pairs for n_ops steps, trace entries for the first n_trace
  task automatic model_run(input int n_ops, input int n_trace);
    logic [AW-1:0] pc;
    logic [AW-1:0] pc1;
    logic          f;
    logic          acc;
    logic          op;
    logic [1:0]    d;
    pc  = '0;
    f   = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      pc1 = pc + AW'(1);
      ops_q.push_back({tb_mem[pc], tb_mem[pc1]});
      op = f ? tb_mem[pc1] : tb_mem[pc];
      d  = {1'b0, op} - {1'b0, acc};
      if (i < n_trace) trace_q.push_back({pc, d[1], d[0]});
      pc  = pc + AW'(1) + AW'(f);
      f   = d[1];
      acc = d[0];
    end
  endtask

  // Monitor: strobe shape, operand stability, operands and trace entries
  int              ph1_cnt    = 0;
  int              ph2_cnt    = 0;
  int              rstn_cnt   = 0;
  int              strobe_err = 0;
  int              pop_cnt    = 0;
  logic            prev_ph1   = 1'b0;
  logic [2*BW-1:0] prev_d     = '0;
  logic [TW-1:0]   exp_t;
  logic [2*BW-1:0] exp_o;

  always @(negedge clk) begin
    if (cpu_ph1) ph1_cnt++;
    if (cpu_ph2) ph2_cnt++;
    if (!cpu_rst_n) rstn_cnt++;
    if (cpu_ph1 && cpu_ph2) strobe_err++;
    if (cpu_ph2 && !prev_ph1) strobe_err++;
    if (cpu_ph1 && prev_ph1) strobe_err++;
    if ((cpu_ph1 || cpu_ph2) && !cpu_ena) strobe_err++;
    if ((cpu_ph1 || cpu_ph2) && ({cpu_data0, cpu_data1} != prev_d)) strobe_err++;
    if (cpu_ph1) begin
      exp_o = (ops_q.size() != 0) ? ops_q.pop_front() : ~{cpu_data0, cpu_data1};
      check_eq("operands", 32'({cpu_data0, cpu_data1}), 32'(exp_o));
    end
    if (trace_valid && trace_ready) begin
      pop_cnt++;
      exp_t = (trace_q.size() != 0) ? trace_q.pop_front() : ~trace_data;
      check_eq("trace", 32'(trace_data), 32'(exp_t));
    end
    prev_ph1 = cpu_ph1;
    prev_d   = {cpu_data0, cpu_data1};
  end

  // Drive helpers: inputs change 1 time unit after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int a, input logic [BW-1:0] v);
    ld_valid = 1'b1;
    ld_addr  = AW'(a);
    ld_data  = v;
    tick(1);
    ld_valid = 1'b0;
  endtask

  task automatic kick(input int n);
    n_steps = 16'(n);
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 2000) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic wait_drain;
    int c;
    c = 0;
    while (trace_valid && c < 50) begin
      tick(1);
      c++;
    end
    check_eq("drain", 32'(trace_valid), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({busy, done, cpu_ena, cpu_ph1, cpu_ph2, cpu_rst_n, trace_valid,
                cpu_data0, cpu_data1});
  endfunction

  int cyc;
  int p1;
  int r1;
  int pc0;
  int k;
  int guard;

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; abort = 1'b0; n_steps = '0; trace_ready = 1'b0;
    tick(3);
    check_eq("reset_outputs", out_vec(), 32'h008);
    rst = 1'b0;
    tick(1);

    // Run 1: mem={1,0,1,1}, three steps
    tb_mem[0] = 1'b1; tb_mem[1] = 1'b0; tb_mem[2] = 1'b1; tb_mem[3] = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, tb_mem[i]);
    trace_ready = 1'b1;
    model_run(3, 0);
    trace_q.push_back({2'd0, 1'b0, 1'b1});
    trace_q.push_back({2'd1, 1'b1, 1'b1});
    trace_q.push_back({2'd2, 1'b0, 1'b0});
    p1 = ph1_cnt; r1 = rstn_cnt; pc0 = pop_cnt;
    kick(3);
    wait_done(cyc);
    check_eq("run1_done", 32'(done), 32'd1);
    check_eq("run1_cycles", 32'(cyc), 32'd14);
    check_eq("run1_busy", 32'(busy), 32'd0);
    wait_drain();
    check_eq("run1_pops", 32'(pop_cnt - pc0), 32'd3);
    check_eq("run1_ph1", 32'(ph1_cnt - p1), 32'd3);
    check_eq("run1_rstn", 32'(rstn_cnt - r1), 32'd1);

    // Run 2: pc wraps from 3 with flag set, restarted straight from DONE
    tb_mem[0] = 1'b0; tb_mem[1] = 1'b1; tb_mem[2] = 1'b0; tb_mem[3] = 1'b0;
    for (int i = 0; i < DEPTH; i++) load(i, tb_mem[i]);
    model_run(5, 5);
    pc0 = pop_cnt;
    kick(5);
    wait_done(cyc);
    check_eq("run2_done", 32'(done), 32'd1);
    check_eq("run2_cycles", 32'(cyc), 32'd22);
    wait_drain();
    check_eq("run2_pops", 32'(pop_cnt - pc0), 32'd5);

    // Run 3: backpressure; a load during the stall must be ignored
    trace_ready = 1'b0;
    model_run(6, 6);
    p1 = ph1_cnt; pc0 = pop_cnt;
    kick(6);
    tick(40);
    check_eq("stall_busy", 32'(busy), 32'd1);
    check_eq("stall_ena", 32'(cpu_ena), 32'd1);
    check_eq("stall_done", 32'(done), 32'd0);
    check_eq("stall_ph1", 32'(ph1_cnt - p1), 32'd5);
    load(1, 1'b0);
    trace_ready = 1'b1;
    wait_done(cyc);
    check_eq("run3_done", 32'(done), 32'd1);
    wait_drain();
    check_eq("run3_pops", 32'(pop_cnt - pc0), 32'd6);

    // Run 4: abort in the second step's PH2
    model_run(2, 1);
    pc0 = pop_cnt;
    kick(4);
    k = 0; guard = 0;
    while (k < 2 && guard < 200) begin
      if (cpu_ph2) k++;
      if (k < 2) begin
        tick(1);
        guard++;
      end
    end
    check_eq("abort_reached_ph2", 32'(cpu_ph2), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_outputs", out_vec() & 32'h1F8, 32'h008);
    tick(3);
    check_eq("abort_pops", 32'(pop_cnt - pc0), 32'd1);
    check_eq("abort_ops_left", 32'(ops_q.size()), 32'd0);

    // abort and start together in IDLE: abort wins
    abort = 1'b1; start = 1'b1; n_steps = 16'd2;
    tick(1);
    abort = 1'b0; start = 1'b0;
    check_eq("abort_start_busy", 32'(busy), 32'd0);
    check_eq("abort_start_rstn", 32'(cpu_rst_n), 32'd1);

    // Load after abort is accepted
    tb_mem[0] = 1'b1;
    load(0, 1'b1);

    // Run 5: zero steps
    p1 = ph1_cnt; r1 = rstn_cnt; pc0 = pop_cnt;
    kick(0);
    wait_done(cyc);
    check_eq("zero_cycles", 32'(cyc), 32'd2);
    tick(2);
    check_eq("zero_ph1", 32'(ph1_cnt - p1), 32'd0);
    check_eq("zero_rstn", 32'(rstn_cnt - r1), 32'd1);
    check_eq("zero_pops", 32'(pop_cnt - pc0), 32'd0);

    // Run 6: uses the word written after abort
    model_run(4, 4);
    pc0 = pop_cnt;
    kick(4);
    wait_done(cyc);
    check_eq("run6_cycles", 32'(cyc), 32'd18);
    wait_drain();
    check_eq("run6_pops", 32'(pop_cnt - pc0), 32'd4);

    // Run 7: synchronous reset mid-run
    model_run(4, 4);
    kick(4);
    tick(7);
    rst = 1'b1;
    tick(1);
    check_eq("midrun_reset", out_vec(), 32'h008);
    rst = 1'b0;
    trace_q.delete();
    ops_q.delete();
    tick(3);
    check_eq("post_reset_idle", out_vec(), 32'h008);

    check_eq("strobe_timing", 32'(strobe_err), 32'd0);
    check_eq("ph1_ph2_pairs", 32'(ph2_cnt), 32'(ph1_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
